// File: rtl/param_seq_counter_pkg.sv
// Shared constants, step classification and the binary-to-Gray helper
// for the parameterised up/down counter.
package param_seq_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 3;
  localparam int unsigned DEFAULT_RESET_VAL = 0;
  localparam int unsigned GRAY_MAX_W        = 32;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_INC,
    STEP_DEC,
    STEP_BOUND,
    STEP_RANGE
  } step_e;

  function automatic logic [GRAY_MAX_W-1:0] to_gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/param_seq_counter_bin2gray.sv
// Combinational binary-to-Gray converter of configurable width.
module bin2gray
  import param_seq_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  always_comb begin
    gray = WIDTH'(to_gray(GRAY_MAX_W'(bin)));
  end

endmodule

// File: rtl/param_seq_counter.sv
// Modulo up/down counter with load, saturate/wrap choice, Gray output view
// and a registered terminal-count pulse.
module param_seq_counter
  import param_seq_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic             gray,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] gray_code;
  step_e            step;

  // An out-of-range value (mod_max lowered beneath it) is handled before the
  // direction-specific boundaries so dir cannot influence the recovery.
  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      if (cnt_q > mod_max) begin
        step = STEP_RANGE;
      end else if (dir) begin
        step = (cnt_q == mod_max) ? STEP_BOUND : STEP_INC;
      end else begin
        step = (cnt_q == '0) ? STEP_BOUND : STEP_DEC;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    unique case (step)
      STEP_HOLD: cnt_d = cnt_q;
      STEP_LOAD: cnt_d = (load_val > mod_max) ? mod_max : load_val;
      STEP_INC:  cnt_d = cnt_q + WIDTH'(1);
      STEP_DEC:  cnt_d = cnt_q - WIDTH'(1);
      STEP_BOUND: begin
        tc_d = 1'b1;
        if (dir) cnt_d = sat ? mod_max : '0;
        else     cnt_d = sat ? '0 : mod_max;
      end
      STEP_RANGE: begin
        tc_d  = 1'b1;
        cnt_d = sat ? mod_max : '0;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= WIDTH'(RESET_VAL);
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (cnt_q),
    .gray (gray_code)
  );

  always_comb begin
    bin_count = cnt_q;
    count     = gray ? gray_code : cnt_q;
    tc        = tc_q;
  end

endmodule

// File: tb/tb_param_seq_counter.sv
// Directed vector bench for param_seq_counter (WIDTH=3, RESET_VAL=0).
module tb_param_seq_counter;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst, en, load, dir, sat, gray;
  logic [W-1:0] load_val, mod_max;
  logic [W-1:0] count, bin_count;
  logic         tc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         rst, load, en, dir, sat, gray;
    logic [W-1:0] lv, mm;
    logic [W-1:0] exp_bin, exp_cnt;
    logic         exp_tc;
    string        name;
  } vec_t;

  vec_t vecs[$];

  param_seq_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .dir       (dir),
    .sat       (sat),
    .gray      (gray),
    .mod_max   (mod_max),
    .count     (count),
    .bin_count (bin_count),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, l, e, d, s, g,
                              input int lv, mm, eb, ec, input logic et,
                              input string nm);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.dir = d; v.sat = s; v.gray = g;
    v.lv = W'(lv); v.mm = W'(mm); v.exp_bin = W'(eb); v.exp_cnt = W'(ec);
    v.exp_tc = et; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] eb, ec, input logic et);
    tests++;
    if (bin_count !== eb) begin
      fails++;
      $display("FAIL %s bin_count: got %0d expected %0d", nm, bin_count, eb);
    end
    tests++;
    if (count !== ec) begin
      fails++;
      $display("FAIL %s count: got %b expected %b", nm, count, ec);
    end
    tests++;
    if (tc !== et) begin
      fails++;
      $display("FAIL %s tc: got %b expected %b", nm, tc, et);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; load = v.load; en = v.en; dir = v.dir; sat = v.sat;
    gray = v.gray; load_val = v.lv; mod_max = v.mm;
    @(posedge clk);
    #1;
    check(v.name, v.exp_bin, v.exp_cnt, v.exp_tc);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; gray = 1'b0;
    load_val = '0; mod_max = 3'd7;

    //                  r  l  e  d  s  g  lv mm eb ec tc
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 7, 0, 0, 0, "reset"));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7, i, i, 0, "up_bin"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7, 0, 0, 1, "up_wrap"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7, 1, 1, 0, "up_after_wrap"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7, 2, 2, 0, "up_after_wrap2"));

    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 7, 0, 0, 0, "reset_gray"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 1, 1, 0, "gray1"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 2, 3, 0, "gray2"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 3, 2, 0, "gray3"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 4, 6, 0, "gray4"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 5, 7, 0, "gray5"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 6, 5, 0, "gray6"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 7, 4, 0, "gray7"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 7, 0, 0, 1, "gray_wrap"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 7, 0, 0, 0, "hold_clears_tc"));

    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 2, 5, 2, 2, 0, "load2"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 1, 1, 0, "down1"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 0, 0, "down0"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 0, 1, "sat_low_a"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 0, 1, "sat_low_b"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5, 5, 5, 1, "down_wrap"));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 5, 5, 5, 1, "sat_high_a"));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 5, 5, 5, 1, "sat_high_b"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 4, 4, 0, "dir_flip"));

    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 6, 7, 6, 6, 0, "load6"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 1, "range_wrap"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 6, 7, 6, 6, 0, "load6b"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4, 4, 4, 1, "range_sat"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4, 4, 4, 0, "hold_after_range"));

    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 7, 3, 3, 3, 0, "load_clamp"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 1, "clamp_wrap"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2, 3, 2, 2, 0, "load_in_range"));

    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "mm0_up"));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, "mm0_down"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "mm0_down_wrap"));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-count overriding load and en, then resume from RESET_VAL.
    apply(mk(1, 0, 0, 1, 0, 0, 0, 7, 0, 0, 0, "rst_pre"));
    for (int i = 1; i <= 5; i++)
      apply(mk(0, 0, 1, 1, 0, 0, 0, 7, i, i, 0, "count_to5"));
    apply(mk(1, 1, 1, 1, 0, 0, 6, 7, 0, 0, 0, "rst_over_load"));
    apply(mk(0, 0, 1, 1, 0, 0, 0, 7, 1, 1, 0, "resume1"));
    apply(mk(0, 0, 1, 1, 0, 0, 0, 7, 2, 2, 0, "resume2"));

    // Gray view is combinational: toggling it changes count, not state.
    @(negedge clk);
    en = 1'b0; gray = 1'b1;
    #1;
    check("gray_toggle_on", 3'd2, 3'd3, 1'b0);
    gray = 1'b0;
    #1;
    check("gray_toggle_off", 3'd2, 3'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
